// File: rtl/sobel_pkg.sv
// Shared types for the sobel frame arbiter: the PCIe beat format, arbiter
// state encoding and a slot-to-one-hot helper.
package sobel_pkg;

    localparam int SOBEL_FRAME_W = 640;
    localparam int SLOT_W        = 3;
    localparam int PIX_W         = 32;
    localparam int PAD_W         = 4;

    typedef struct packed {
        logic              valid;
        logic              last;
        logic [PIX_W-1:0]  data;
        logic [SLOT_W-1:0] slot;
        logic [PAD_W-1:0]  pad;
    } PCIEPacket;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2,
        FLUSH  = 2'd3
    } sobel_arb_state_t;

    function automatic logic [7:0] slot_onehot(input logic [SLOT_W-1:0] idx);
        return 8'd1 << idx;
    endfunction

endpackage

// File: rtl/sobel_rr_arbiter.sv
// Combinational round-robin pick: first asserted request strictly after
// rr_ptr, wrapping, returned as one-hot and index.
module sobel_rr_arbiter
    import sobel_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [SLOT_W-1:0]  rr_ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [SLOT_W-1:0]  grant_idx,
    output logic               grant_valid
);

    logic [SLOT_W:0] cand_s;

    // Scan rr_ptr+1 .. rr_ptr+NUM_REQ modulo NUM_REQ; the first hit wins.
    always_comb begin
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        cand_s      = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand_s = {1'b0, rr_ptr} + (SLOT_W + 1)'(i);
            if (cand_s >= (SLOT_W + 1)'(NUM_REQ)) begin
                cand_s = cand_s - (SLOT_W + 1)'(NUM_REQ);
            end else begin
                cand_s = cand_s;
            end
            if (!grant_valid && (|(req & (NUM_REQ'(1) << cand_s)))) begin
                grant_valid = 1'b1;
                grant       = NUM_REQ'(1) << cand_s;
                grant_idx   = cand_s[SLOT_W-1:0];
            end else begin
                grant_valid = grant_valid;
            end
        end
    end

endmodule

// File: rtl/sobel_frame_arbiter.sv
// Time-shares one sobel_unit among NUM_REQ streams a whole frame at a time,
// then drains and resets the unit before the next round-robin grant.
module sobel_frame_arbiter
    import sobel_pkg::*;
#(
    parameter int NUM_REQ  = 4,
    parameter int FRAME_W  = SOBEL_FRAME_W,
    parameter int FRAME_H  = 480,
    parameter int PIPE_LAT = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  PCIEPacket          req_packet_in [NUM_REQ],
    output logic [NUM_REQ-1:0] req_ready,
    output PCIEPacket          sobel_packet_out,
    output logic               sobel_rst,
    input  PCIEPacket          sobel_packet_in,
    output PCIEPacket          pcie_packet_out,
    output logic [SLOT_W-1:0]  grant_slot,
    output logic               busy,
    output logic               frame_done,
    output logic               err_len
);

    localparam int TOTAL = FRAME_W * FRAME_H;
    localparam int CNT_W = $clog2(TOTAL + 1);
    localparam int DRN_W = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;

    sobel_arb_state_t   state_r, state_s;
    logic [SLOT_W-1:0]  rr_ptr_r, grant_slot_r;
    logic [CNT_W-1:0]   pix_cnt_r;
    logic [DRN_W-1:0]   drain_cnt_r;
    logic               err_len_r, frame_done_r;
    logic [NUM_REQ-1:0] req_valid_s, arb_grant_s;
    logic [SLOT_W-1:0]  arb_idx_s;
    logic               arb_valid_s;
    PCIEPacket          sel_s;
    logic               accept_s, cnt_end_s, end_s;

    // Gather per-requester valids and select the granted stream.
    always_comb begin
        req_valid_s = '0;
        sel_s       = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_valid_s[i] = req_packet_in[i].valid;
            if (grant_slot_r == SLOT_W'(i)) begin
                sel_s = req_packet_in[i];
            end else begin
                sel_s = sel_s;
            end
        end
    end

    sobel_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .req         (req_valid_s),
        .rr_ptr      (rr_ptr_r),
        .grant       (arb_grant_s),
        .grant_idx   (arb_idx_s),
        .grant_valid (arb_valid_s)
    );

    assign accept_s  = (state_r == STREAM) && sel_s.valid;
    assign cnt_end_s = (pix_cnt_r == CNT_W'(TOTAL - 1));
    assign end_s     = accept_s && (sel_s.last || cnt_end_s);

    // Next-state logic for the frame sequence.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE:    state_s = arb_valid_s ? STREAM : IDLE;
            STREAM:  state_s = end_s ? DRAIN : STREAM;
            DRAIN:   state_s = (drain_cnt_r == DRN_W'(PIPE_LAT - 1)) ? FLUSH : DRAIN;
            FLUSH:   state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // State, grant, counters and sticky length error.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= IDLE;
            rr_ptr_r     <= SLOT_W'(NUM_REQ - 1);
            grant_slot_r <= '0;
            pix_cnt_r    <= '0;
            drain_cnt_r  <= '0;
            err_len_r    <= 1'b0;
            frame_done_r <= 1'b0;
        end else begin
            state_r <= state_s;
            if (state_r == IDLE && arb_valid_s) begin
                rr_ptr_r     <= arb_idx_s;
                grant_slot_r <= arb_idx_s;
            end
            if (state_r == FLUSH) begin
                pix_cnt_r <= '0;
            end else if (accept_s) begin
                pix_cnt_r <= pix_cnt_r + CNT_W'(1);
            end
            if (end_s) begin
                drain_cnt_r <= '0;
            end else if (state_r == DRAIN) begin
                drain_cnt_r <= drain_cnt_r + DRN_W'(1);
            end
            // Early last or a count-terminated frame without last.
            if (end_s && (sel_s.last != cnt_end_s)) begin
                err_len_r <= 1'b1;
            end
            frame_done_r <= (state_s == FLUSH) && (state_r != FLUSH);
        end
    end

    // Only the granted requester sees ready, and only while streaming.
    always_comb begin
        req_ready        = '0;
        sobel_packet_out = '0;
        if (state_r == STREAM) begin
            req_ready              = NUM_REQ'(slot_onehot(grant_slot_r));
            sobel_packet_out.valid = sel_s.valid;
            sobel_packet_out.last  = sel_s.valid && (sel_s.last || cnt_end_s);
            sobel_packet_out.data  = sel_s.data;
        end else begin
            req_ready        = '0;
            sobel_packet_out = '0;
        end
    end

    assign sobel_rst = rst || (state_r == FLUSH);

    // Tag results with the owning slot; suppress beats while the unit is in reset.
    always_comb begin
        pcie_packet_out      = sobel_packet_in;
        pcie_packet_out.slot = grant_slot_r;
        pcie_packet_out.pad  = '0;
        if (sobel_rst) begin
            pcie_packet_out.valid = 1'b0;
            pcie_packet_out.last  = 1'b0;
        end else begin
            pcie_packet_out.valid = sobel_packet_in.valid;
            pcie_packet_out.last  = sobel_packet_in.last;
        end
    end

    assign grant_slot = grant_slot_r;
    assign busy       = (state_r != IDLE);
    assign frame_done = frame_done_r;
    assign err_len    = err_len_r;

endmodule

// File: tb/tb_sobel_frame_arbiter.sv
// Self-checking bench: requester beat queues, a delay-line stand-in for
// sobel_unit, and a frame-level reference model of grants and beat flow.
module tb_sobel_frame_arbiter;
    import sobel_pkg::*;

    localparam int NR = 4, FW = 8, FH = 2, PL = 2, TOTAL = FW * FH, QD = 512;

    logic clk = 1'b0;
    logic rst = 1'b1;
    PCIEPacket req_pkt [NR];
    logic [NR-1:0] req_ready;
    PCIEPacket sobel_out, sobel_in, pcie_out;
    logic sobel_rst, busy, frame_done, err_len;
    logic [SLOT_W-1:0] grant_slot;

    sobel_frame_arbiter #(.NUM_REQ(NR), .FRAME_W(FW), .FRAME_H(FH), .PIPE_LAT(PL)) dut (
        .clk(clk), .rst(rst), .req_packet_in(req_pkt), .req_ready(req_ready),
        .sobel_packet_out(sobel_out), .sobel_rst(sobel_rst), .sobel_packet_in(sobel_in),
        .pcie_packet_out(pcie_out), .grant_slot(grant_slot), .busy(busy),
        .frame_done(frame_done), .err_len(err_len)
    );

    always #5 clk = ~clk;

    int n_cmp = 0, n_mis = 0;
    logic [32:0] mem [NR][QD];
    int head [NR], tail [NR];
    bit hold_off [NR];
    bit m_active, m_err, prev_busy;
    int m_slot, m_beats, m_gap, m_rr, m_last_slot;
    PCIEPacket pipe [PL];
    int dlog [64];
    int dlen, done_cnt;

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic enq(int r, int len, bit with_last);
        for (int k = 0; k < len; k++) begin
            mem[r][tail[r] % QD] = {(with_last && k == len - 1), 32'($urandom)};
            tail[r]++;
        end
    endtask

    function automatic bit all_quiet();
        for (int r = 0; r < NR; r++) if (head[r] != tail[r]) return 1'b0;
        return !m_active && m_gap == 0;
    endfunction

    task automatic step();
        logic [NR-1:0] er;
        logic [32:0] hb;
        PCIEPacket exp_out, exp_tag, cap_out;
        bit exp_srst, acc, cap_srst;
        int w;
        for (int r = 0; r < NR; r++) begin
            req_pkt[r].data = 32'($urandom);
            req_pkt[r].slot = SLOT_W'($urandom);
            req_pkt[r].pad  = PAD_W'($urandom);
            req_pkt[r].last = 1'($urandom);
            req_pkt[r].valid = 1'b0;
            if (head[r] != tail[r] && !hold_off[r]) begin
                hb = mem[r][head[r] % QD];
                req_pkt[r].valid = 1'b1;
                req_pkt[r].last  = hb[32];
                req_pkt[r].data  = hb[31:0];
            end
        end
        sobel_in = pipe[PL-1];
        sobel_in.slot = SLOT_W'($urandom);
        sobel_in.pad  = PAD_W'($urandom);
        #1;
        er = m_active ? (NR'(1) << m_slot) : '0;
        exp_srst = !m_active && m_gap == 1;
        chk("ready", 64'(req_ready), 64'(er));
        chk("busy", 64'(busy), 64'(m_active || m_gap > 0));
        chk("sobel_rst", 64'(sobel_rst), 64'(exp_srst));
        chk("frame_done", 64'(frame_done), 64'(exp_srst));
        chk("grant_slot", 64'(grant_slot), 64'(m_last_slot));
        chk("err_len", 64'(err_len), 64'(m_err));
        acc = m_active && req_pkt[m_slot].valid;
        hb = acc ? mem[m_slot][head[m_slot] % QD] : 33'd0;
        if (acc) begin
            exp_out = '0;
            exp_out.valid = 1'b1;
            exp_out.last  = hb[32] || (m_beats == TOTAL - 1);
            exp_out.data  = hb[31:0];
            chk("sobel_out", 64'(sobel_out), 64'(exp_out));
        end else begin
            chk("sobel_out_idle", 64'({sobel_out.valid, sobel_out.last}), 64'd0);
        end
        exp_tag = pipe[PL-1];
        exp_tag.slot = SLOT_W'(m_last_slot);
        exp_tag.pad  = '0;
        if (exp_srst) begin
            exp_tag.valid = 1'b0;
            exp_tag.last  = 1'b0;
        end
        chk("pcie_out", 64'(pcie_out), 64'(exp_tag));
        if (busy && !prev_busy && dlen < 64) begin
            dlog[dlen] = int'(grant_slot);
            dlen++;
        end
        prev_busy = busy;
        if (frame_done) done_cnt++;
        cap_out = sobel_out;
        cap_srst = sobel_rst;
        @(posedge clk);
        for (int p = PL - 1; p > 0; p--) pipe[p] = cap_srst ? '0 : pipe[p-1];
        pipe[0] = cap_srst ? '0 : cap_out;
        pipe[0].data = pipe[0].data ^ 32'h5A5A_5A5A;
        #1;
        for (int r = 0; r < NR; r++) hold_off[r] = 1'b0;
        if (acc) begin
            head[m_slot]++;
            m_beats++;
            hold_off[m_slot] = ($urandom_range(0, 3) == 0);
            if (hb[32] || m_beats == TOTAL) begin
                if (hb[32] != (m_beats == TOTAL)) m_err = 1'b1;
                m_active = 1'b0;
                m_gap = PL + 1;
            end
        end else if (!m_active && m_gap > 0) begin
            m_gap--;
        end else if (!m_active) begin
            w = -1;
            for (int i = 1; i <= NR; i++) begin
                if (w < 0 && req_pkt[(m_rr + i) % NR].valid) w = (m_rr + i) % NR;
            end
            if (w >= 0) begin
                m_active = 1'b1;
                m_slot = w;
                m_rr = w;
                m_last_slot = w;
                m_beats = 0;
            end
        end
    endtask

    task automatic run_idle(string tag, int budget);
        int n = 0;
        while (!all_quiet() && n < budget) begin
            step();
            n++;
        end
        chk(tag, 64'(n < budget), 64'd1);
    endtask

    task automatic do_reset(int n);
        rst = 1'b1;
        for (int r = 0; r < NR; r++) begin
            req_pkt[r] = '0;
            head[r] = tail[r];
            hold_off[r] = 1'b0;
        end
        sobel_in = '0;
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            for (int p = 0; p < PL; p++) pipe[p] = '0;
            #1;
            chk("rst_srst", 64'(sobel_rst), 64'd1);
            chk("rst_ready", 64'(req_ready), 64'd0);
            chk("rst_busy", 64'(busy), 64'd0);
            chk("rst_grant", 64'(grant_slot), 64'd0);
            chk("rst_err", 64'(err_len), 64'd0);
            chk("rst_done", 64'(frame_done), 64'd0);
            chk("rst_sobel_vl", 64'({sobel_out.valid, sobel_out.last}), 64'd0);
            chk("rst_pcie_vl", 64'({pcie_out.valid, pcie_out.last}), 64'd0);
        end
        m_active = 1'b0; m_gap = 0; m_rr = NR - 1; m_last_slot = 0; m_err = 1'b0;
        prev_busy = 1'b0;
        rst = 1'b0;
    endtask

    initial begin
        int exp6 [8] = '{0, 1, 2, 3, 0, 1, 2, 3};
        int d0;
        for (int r = 0; r < NR; r++) begin
            head[r] = 0; tail[r] = 0; req_pkt[r] = '0;
        end
        for (int p = 0; p < PL; p++) pipe[p] = '0;
        sobel_in = '0; dlen = 0; done_cnt = 0;

        // 1: single well-formed frame from req0
        do_reset(3);
        enq(0, TOTAL, 1'b1);
        run_idle("t1_timeout", 200);
        chk("t1_done", 64'(done_cnt), 64'd1);
        chk("t1_err", 64'(err_len), 64'd0);

        // 2: req1 and req2 together with rr_ptr=0
        dlen = 0;
        enq(1, TOTAL, 1'b1);
        enq(2, TOTAL, 1'b1);
        run_idle("t2_timeout", 300);
        chk("t2_len", 64'(dlen), 64'd2);
        chk("t2_first", 64'(dlog[0]), 64'd1);
        chk("t2_second", 64'(dlog[1]), 64'd2);

        // 3: early last from req3, then a normal frame from req1
        enq(3, 6, 1'b1);
        enq(1, TOTAL, 1'b1);
        run_idle("t3_timeout", 300);
        chk("t3_err", 64'(err_len), 64'd1);

        // 4: no last at all, count forces the end
        do_reset(2);
        enq(0, TOTAL, 1'b0);
        run_idle("t4_timeout", 200);
        chk("t4_err", 64'(err_len), 64'd1);

        // 1-pixel frame
        do_reset(2);
        enq(2, 1, 1'b1);
        run_idle("t1px_timeout", 100);
        chk("t1px_err", 64'(err_len), 64'd1);

        // 5: reset in mid-frame
        do_reset(2);
        d0 = done_cnt;
        enq(0, TOTAL, 1'b0);
        for (int k = 0; k < 100 && !(m_active && m_beats == 8); k++) step();
        chk("t5_reached", 64'(m_beats), 64'd8);
        do_reset(1);
        chk("t5_no_done", 64'(done_cnt), 64'(d0));

        // 6: all requesters continuously valid, 8 frames
        dlen = 0;
        for (int r = 0; r < NR; r++) begin
            enq(r, TOTAL, 1'b1);
            enq(r, TOTAL, 1'b1);
        end
        run_idle("t6_timeout", 1000);
        chk("t6_len", 64'(dlen), 64'd8);
        for (int i = 0; i < 8; i++) chk("t6_order", 64'(dlog[i]), 64'(exp6[i]));

        // Randomised rounds
        do_reset(2);
        for (int round = 0; round < 6; round++) begin
            for (int r = 0; r < NR; r++) begin
                if ($urandom_range(0, 1) == 1) begin
                    if ($urandom_range(0, 2) == 0) enq(r, TOTAL, 1'b0);
                    else enq(r, $urandom_range(1, 20), 1'b1);
                end
            end
            run_idle("rand_timeout", 1000);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
